// File: rtl/neuron_layer_scheduler_if.sv
// Stream bundle around the neuron layer scheduler: pixel input, neuron drive/result, layer output.
// Latency: none, signal container only.
// Backpressure: valid/ready on every stream; master = scheduler side, slave = environment side.
interface neuron_layer_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16,
  parameter int SEL_W  = 2
);
  // pixel stream from DMA
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  // pixel replay to the neuron datapath
  logic [DATA_W-1:0] n_tdata;
  logic              n_tvalid;
  logic              n_tlast;
  logic              n_tready;
  logic [SEL_W-1:0]  n_sel;
  // neuron result return
  logic [RES_W-1:0]  n_res_data;
  logic              n_res_valid;
  logic              n_res_ready;
  // layer output stream
  logic [RES_W-1:0]  m_axis_tdata;
  logic              m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output n_tdata, n_tvalid, n_tlast, n_sel,
    input  n_tready,
    input  n_res_data, n_res_valid,
    output n_res_ready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  n_tdata, n_tvalid, n_tlast, n_sel,
    output n_tready,
    output n_res_data, n_res_valid,
    input  n_res_ready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/neuron_layer_scheduler.sv
// Time-multiplexes one neuron datapath over N_NEURONS neurons: buffer one frame, replay it per neuron, forward results.
// Latency: last pixel accepted -> first replayed pixel valid 1 cycle; per neuron N_INPUTS drive + >=1 wait + 1 emit cycles.
// Backpressure: input held off for the whole layer; replay and output stall on n_tready / m_axis_tready.
// Ports: clock, reset (sync, active-high); bus (master modport: s_axis in, n_* drive/result, m_axis out);
//        busy (not loading), frame_err (one-cycle pulse on a frame length/tlast mismatch).
module neuron_layer_scheduler #(
  parameter int N_INPUTS  = 16,
  parameter int N_NEURONS = 4,
  parameter int DATA_W    = 8,
  parameter int RES_W     = 16,
  parameter int SEL_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic clock,
  input  logic reset,
  neuron_layer_scheduler_if.master bus,
  output logic busy,
  output logic frame_err
);

  localparam int CNT_W = $clog2(N_INPUTS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    S_LOAD     = 2'd0,
    S_DRIVE    = 2'd1,
    S_WAIT_RES = 2'd2,
    S_EMIT     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [SEL_W-1:0]   n_sel_q, n_sel_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               frame_err_q, frame_err_d;
  logic [DATA_W-1:0]  buf_q [N_INPUTS];

  logic s_hs, n_hs, r_hs, m_hs;

  // Every valid/ready is decoded from the state register alone and forced low while reset is high.
  assign bus.s_axis_tready = (state_q == S_LOAD)     && !reset;
  assign bus.n_tvalid      = (state_q == S_DRIVE)    && !reset;
  assign bus.n_res_ready   = (state_q == S_WAIT_RES) && !reset;
  assign bus.m_axis_tvalid = (state_q == S_EMIT)     && !reset;

  assign bus.n_tdata      = buf_q[rd_cnt_q];
  assign bus.n_tlast      = (rd_cnt_q == LAST_IDX);
  assign bus.n_sel        = n_sel_q;
  assign bus.m_axis_tdata = res_q;
  assign bus.m_axis_tlast = (n_sel_q == LAST_SEL);
  assign bus.m_axis_tkeep = 1'b1;

  assign busy      = (state_q != S_LOAD) && !reset;
  assign frame_err = frame_err_q;

  assign s_hs = bus.s_axis_tvalid && bus.s_axis_tready;
  assign n_hs = bus.n_tvalid      && bus.n_tready;
  assign r_hs = bus.n_res_valid   && bus.n_res_ready;
  assign m_hs = bus.m_axis_tvalid && bus.m_axis_tready;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    n_sel_d     = n_sel_q;
    res_d       = res_q;
    frame_err_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (s_hs) begin
          if (wr_cnt_q == LAST_IDX) begin
            // Frame length is fixed: a missing tlast is flagged but the frame is still used.
            frame_err_d = !bus.s_axis_tlast;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            n_sel_d     = '0;
            state_d     = S_DRIVE;
          end else if (bus.s_axis_tlast) begin
            // Short frame: drop it and start collecting again from slot 0.
            frame_err_d = 1'b1;
            wr_cnt_d    = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRIVE: begin
        if (n_hs) begin
          if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d = '0;
            state_d  = S_WAIT_RES;
          end else begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
          end
        end
      end
      S_WAIT_RES: begin
        if (r_hs) begin
          res_d   = bus.n_res_data;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (m_hs) begin
          if (n_sel_q == LAST_SEL) begin
            n_sel_d = '0;
            state_d = S_LOAD;
          end else begin
            n_sel_d = n_sel_q + SEL_W'(1);
            state_d = S_DRIVE;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      n_sel_q     <= '0;
      res_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      n_sel_q     <= n_sel_d;
      res_q       <= res_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame buffer: written only while loading, so it stays intact across all neuron passes.
  always_ff @(posedge clock) begin
    if (s_hs) begin
      buf_q[wr_cnt_q] <= bus.s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Self-checking bench for neuron_layer_scheduler: frame-level reference model plus neuron and sink responders.
// Latency: n/a.
// Backpressure: optional random stalls on n_tready, n_res_valid and m_axis_tready.
module tb_neuron_layer_scheduler;
  localparam int N_IN  = 16;
  localparam int N_NEU = 4;
  localparam int DW    = 8;
  localparam int RW    = 16;
  localparam int SW    = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy, frame_err;

  always #5 clock = ~clock;

  neuron_layer_scheduler_if #(.DATA_W(DW), .RES_W(RW), .SEL_W(SW)) bus ();

  neuron_layer_scheduler #(
    .N_INPUTS(N_IN), .N_NEURONS(N_NEU), .DATA_W(DW), .RES_W(RW), .SEL_W(SW)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy), .frame_err(frame_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit stall_en = 1'b0;
  bit spur_en  = 1'b0;

  // ---------------- reference model ----------------
  typedef struct { int data; bit last; int sel; } pix_t;
  typedef struct { int data; bit last; } out_t;
  pix_t exp_pix[$];
  out_t exp_out[$];
  int   frame [N_IN];
  int   beats = 0;
  bit   ferr_next = 1'b0;
  bit   layer_active = 1'b0, driving = 1'b0, awaiting = 1'b0, res_pend = 1'b0;
  int   layers_done = 0;
  int   ferr_count = 0;
  int   mlog[$];
  bit   mlast_log[$];
  bit   pn_stall = 1'b0, pm_stall = 1'b0;
  int   pn_dat, pn_last, pn_sel, pm_dat, pm_last;

  always @(negedge clock) begin : mon
    pix_t p;
    out_t o;
    int   sum;
    if (reset) begin
      chk("rst_s_tready", bus.s_axis_tready, 0);
      chk("rst_n_tvalid", bus.n_tvalid, 0);
      chk("rst_n_res_ready", bus.n_res_ready, 0);
      chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
      exp_pix.delete();
      exp_out.delete();
      beats = 0; ferr_next = 0;
      layer_active = 0; driving = 0; awaiting = 0; res_pend = 0;
      pn_stall = 0; pm_stall = 0;
    end else begin
      chk("frame_err", frame_err, ferr_next);
      if (frame_err) ferr_count++;
      ferr_next = 0;
      chk("s_tready", bus.s_axis_tready, !layer_active);
      chk("busy", busy, layer_active);
      chk("n_tvalid", bus.n_tvalid, driving);
      chk("n_res_ready", bus.n_res_ready, awaiting);
      chk("m_tvalid", bus.m_axis_tvalid, res_pend);
      chk("m_tkeep", bus.m_axis_tkeep, 1);
      if (!layer_active) chk("idle_n_sel", bus.n_sel, 0);
      if (pn_stall) begin
        chk("n_stall_data", bus.n_tdata, pn_dat);
        chk("n_stall_last", bus.n_tlast, pn_last);
        chk("n_stall_sel", bus.n_sel, pn_sel);
      end
      if (pm_stall) begin
        chk("m_stall_data", bus.m_axis_tdata, pm_dat);
        chk("m_stall_last", bus.m_axis_tlast, pm_last);
      end
      pn_stall = bus.n_tvalid && !bus.n_tready;
      pn_dat = bus.n_tdata; pn_last = bus.n_tlast; pn_sel = bus.n_sel;
      pm_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      pm_dat = bus.m_axis_tdata; pm_last = bus.m_axis_tlast;

      // input frame collection
      if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        frame[beats] = bus.s_axis_tdata;
        if (beats == N_IN - 1) begin
          ferr_next = !bus.s_axis_tlast;
          beats = 0;
          layer_active = 1; driving = 1;
          sum = 0;
          for (int i = 0; i < N_IN; i++) sum += frame[i];
          for (int k = 0; k < N_NEU; k++) begin
            for (int i = 0; i < N_IN; i++) begin
              p.data = frame[i]; p.last = (i == N_IN - 1); p.sel = k;
              exp_pix.push_back(p);
            end
            o.data = (sum + k) & 16'hFFFF; o.last = (k == N_NEU - 1);
            exp_out.push_back(o);
          end
        end else if (bus.s_axis_tlast) begin
          ferr_next = 1;
          beats = 0;
        end else begin
          beats++;
        end
      end
      // replayed pixels
      if (bus.n_tvalid && bus.n_tready) begin
        if (exp_pix.size() == 0) chk("n_beat_unexpected", 1, 0);
        else begin
          p = exp_pix.pop_front();
          chk("n_tdata", bus.n_tdata, p.data);
          chk("n_tlast", bus.n_tlast, p.last);
          chk("n_sel", bus.n_sel, p.sel);
          if (p.last) begin driving = 0; awaiting = 1; end
        end
      end
      if (bus.n_res_valid && bus.n_res_ready) begin
        awaiting = 0; res_pend = 1;
      end
      // layer outputs
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_out.size() == 0) chk("m_beat_unexpected", 1, 0);
        else begin
          o = exp_out.pop_front();
          chk("m_tdata", bus.m_axis_tdata, o.data);
          chk("m_tlast", bus.m_axis_tlast, o.last);
          mlog.push_back(bus.m_axis_tdata);
          mlast_log.push_back(bus.m_axis_tlast);
          res_pend = 0;
          if (o.last) begin layer_active = 0; layers_done++; end
          else driving = 1;
        end
      end
    end
  end

  // ---------------- neuron responder: result = sum of pass pixels + n_sel ----------------
  initial begin : neuron
    int acc;
    int pend[$];
    bit spur_now;
    acc = 0; spur_now = 0;
    bus.n_tready = 1'b0; bus.n_res_valid = 1'b0; bus.n_res_data = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        acc = 0;
        pend.delete();
      end else begin
        if (bus.n_res_valid && bus.n_res_ready && !spur_now && pend.size() > 0)
          void'(pend.pop_front());
        if (bus.n_tvalid && bus.n_tready) begin
          acc += bus.n_tdata;
          if (bus.n_tlast) begin
            pend.push_back(acc + bus.n_sel);
            acc = 0;
          end
        end
      end
      @(posedge clock); #1;
      bus.n_tready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (pend.size() > 0) begin
        bus.n_res_valid = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.n_res_data  = RW'(pend[0]);
        spur_now = 0;
      end else if (spur_en && $urandom_range(0, 2) == 0) begin
        bus.n_res_valid = 1'b1;
        bus.n_res_data  = 16'hDEAD;
        spur_now = 1;
      end else begin
        bus.n_res_valid = 1'b0;
        spur_now = 0;
      end
    end
  end

  // ---------------- output sink ----------------
  initial begin
    bus.m_axis_tready = 1'b0;
    forever begin
      @(posedge clock); #1;
      bus.m_axis_tready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_frame(input int nbeats, input int tlast_idx, input bit ramp);
    int  t;
    bit  hs;
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clock); #1;
      if (stall_en && $urandom_range(0, 3) == 0) begin
        bus.s_axis_tvalid = 1'b0;
        @(posedge clock); #1;
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = ramp ? DW'(i) : DW'($urandom_range(0, 255));
      bus.s_axis_tlast  = (i == tlast_idx);
      t = 0;
      do begin
        @(negedge clock);
        hs = bus.s_axis_tready;
        t++;
      end while (!hs && t < 3000);
      if (!hs) begin
        chk("s_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_layers(input int target);
    int t;
    t = 0;
    while (layers_done < target && t < 5000) begin
      @(posedge clock);
      t++;
    end
    chk("layer_done_in_time", (layers_done >= target) ? 1 : 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  initial begin
    int f0, ld, t;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tlast = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    idle(2);

    // ramp frame, all ready: results 120..123, tlast on the last only
    mlog.delete(); mlast_log.delete();
    send_frame(N_IN, N_IN - 1, 1'b1);
    wait_layers(1);
    @(negedge clock);
    chk("t1_busy_low", busy, 0);
    chk("t1_count", mlog.size(), 4);
    if (mlog.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t1_result", mlog[k], 120 + k);
        chk("t1_tlast", mlast_log[k], (k == 3) ? 1 : 0);
      end
    end

    // early tlast on beat 5: dropped, one error pulse, then a good frame
    f0 = ferr_count;
    send_frame(6, 5, 1'b0);
    idle(4);
    chk("t2_ferr_pulses", ferr_count - f0, 1);
    chk("t2_no_layer", layers_done, 1);
    mlog.delete();
    send_frame(N_IN, N_IN - 1, 1'b0);
    wait_layers(2);
    chk("t2_count", mlog.size(), 4);

    // beat 15 without tlast: error pulse, layer still computed
    f0 = ferr_count;
    mlog.delete();
    send_frame(N_IN, -1, 1'b0);
    wait_layers(3);
    idle(2);
    chk("t3_ferr_pulses", ferr_count - f0, 1);
    chk("t3_count", mlog.size(), 4);

    // random stalls and spurious result pulses: ramp must give the same results
    stall_en = 1'b1; spur_en = 1'b1;
    mlog.delete();
    send_frame(N_IN, N_IN - 1, 1'b1);
    wait_layers(4);
    chk("t4_count", mlog.size(), 4);
    if (mlog.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("t4_result", mlog[k], 120 + k);
    end
    for (int f = 0; f < 5; f++) begin
      send_frame(N_IN, N_IN - 1, 1'b0);
      wait_layers(5 + f);
    end
    stall_en = 1'b0;

    // reset during the n_sel=2 pass
    ld = layers_done;
    send_frame(N_IN, N_IN - 1, 1'b0);
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!(bus.n_tvalid && bus.n_sel == 2) && t < 3000);
    chk("t5_reached_sel2", (bus.n_tvalid && bus.n_sel == 2) ? 1 : 0, 1);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("t5_busy", busy, 0);
    chk("t5_n_sel", bus.n_sel, 0);
    chk("t5_n_tvalid", bus.n_tvalid, 0);
    chk("t5_m_tvalid", bus.m_axis_tvalid, 0);
    chk("t5_no_layer", layers_done, ld);
    mlog.delete(); mlast_log.delete();
    send_frame(N_IN, N_IN - 1, 1'b0);
    wait_layers(ld + 1);
    idle(20);
    chk("t5_count", mlog.size(), 4);
    chk("t5_layers", layers_done, ld + 1);
    if (mlast_log.size() == 4) chk("t5_tlast", mlast_log[3], 1);
    spur_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
